// File: rtl/game_sprite_motion_if.sv
// Strobe, raster and status bundle between the game master FSM and one sprite motion engine.
interface game_sprite_motion_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10
);
    logic                      write_xy;
    logic                      write_dxy;
    logic                      enable_update;
    logic [X_WIDTH-1:0]        pixel_x;
    logic [Y_WIDTH-1:0]        pixel_y;
    logic signed [X_WIDTH:0]   sprite_x;
    logic signed [Y_WIDTH:0]   sprite_y;
    logic                      within_screen;
    logic                      pixel_hit;

    modport master (
        output write_xy, write_dxy, enable_update, pixel_x, pixel_y,
        input  sprite_x, sprite_y, within_screen, pixel_hit
    );

    modport slave (
        input  write_xy, write_dxy, enable_update, pixel_x, pixel_y,
        output sprite_x, sprite_y, within_screen, pixel_hit
    );
endinterface

// File: rtl/game_sprite_motion.sv
// Per-sprite position/velocity engine with on-screen freeze and registered pixel hit.
// Define GAME_SPRITE_VSYNC_TICK_EN to step on an external vsync_tick instead of the STROBE_DIV divider.
module game_sprite_motion #(
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int D_WIDTH       = 3,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SPRITE_W      = 8,
    parameter int SPRITE_H      = 8,
    parameter int START_X       = 320,
    parameter int START_Y       = 400,
    parameter int START_DX      = 1,
    parameter int START_DY      = -1,
    parameter int STROBE_DIV    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    game_sprite_motion_if.slave  bus
`ifdef GAME_SPRITE_VSYNC_TICK_EN
    ,
    input  logic                 vsync_tick
`endif
);
    localparam int XE = X_WIDTH + 2;
    localparam int YE = Y_WIDTH + 2;

    localparam logic signed [X_WIDTH:0]   X_INIT  = (X_WIDTH+1)'(START_X);
    localparam logic signed [Y_WIDTH:0]   Y_INIT  = (Y_WIDTH+1)'(START_Y);
    localparam logic signed [D_WIDTH-1:0] DX_INIT = D_WIDTH'(START_DX);
    localparam logic signed [D_WIDTH-1:0] DY_INIT = D_WIDTH'(START_DY);
    localparam logic signed [XE-1:0]      SPR_W   = XE'(SPRITE_W);
    localparam logic signed [YE-1:0]      SPR_H   = YE'(SPRITE_H);
    localparam logic signed [XE-1:0]      SCR_W   = XE'(SCREEN_WIDTH);
    localparam logic signed [YE-1:0]      SCR_H   = YE'(SCREEN_HEIGHT);

    logic signed [X_WIDTH:0]   x;
    logic signed [Y_WIDTH:0]   y;
    logic signed [D_WIDTH-1:0] dx;
    logic signed [D_WIDTH-1:0] dy;
    logic                      within_screen;
    logic                      pixel_hit;
    logic                      tick;

    logic signed [X_WIDTH:0]   dx_ext;
    logic signed [Y_WIDTH:0]   dy_ext;
    logic signed [XE-1:0]      x_lo, x_hi, px;
    logic signed [YE-1:0]      y_lo, y_hi, py;
    logic                      on_screen;
    logic                      hit_next;

    assign dx_ext = {{(X_WIDTH+1-D_WIDTH){dx[D_WIDTH-1]}}, dx};
    assign dy_ext = {{(Y_WIDTH+1-D_WIDTH){dy[D_WIDTH-1]}}, dy};

    // Extra headroom bit so x+SPRITE_W cannot overflow near the right edge.
    assign x_lo = {x[X_WIDTH], x};
    assign y_lo = {y[Y_WIDTH], y};
    assign x_hi = x_lo + SPR_W;
    assign y_hi = y_lo + SPR_H;
    assign px   = {2'b00, bus.pixel_x};
    assign py   = {2'b00, bus.pixel_y};

    always_comb begin
        on_screen = 1'b0;
        hit_next  = 1'b0;
        on_screen = !x[X_WIDTH] && (x_hi <= SCR_W) && !y[Y_WIDTH] && (y_hi <= SCR_H);
        hit_next  = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
    end

`ifdef GAME_SPRITE_VSYNC_TICK_EN
    assign tick = bus.enable_update & within_screen & vsync_tick;
`else
    localparam int CW = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_DIV - 1);

    logic [CW-1:0] step_cnt;
    logic          step_en;

    assign step_en = bus.enable_update & within_screen;
    assign tick    = step_en & (step_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (bus.write_xy) begin
            step_cnt <= '0;
        end else if (step_en) begin
            step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x             <= X_INIT;
            y             <= Y_INIT;
            dx            <= '0;
            dy            <= '0;
            within_screen <= 1'b1;
            pixel_hit     <= 1'b0;
        end else begin
            // A tick coinciding with write_dxy still moves by the old velocity.
            if (bus.write_xy) begin
                x <= X_INIT;
                y <= Y_INIT;
            end else if (tick) begin
                x <= x + dx_ext;
                y <= y + dy_ext;
            end
            if (bus.write_dxy) begin
                dx <= DX_INIT;
                dy <= DY_INIT;
            end
            within_screen <= on_screen;
            pixel_hit     <= hit_next;
        end
    end

    assign bus.sprite_x      = x;
    assign bus.sprite_y      = y;
    assign bus.within_screen = within_screen;
    assign bus.pixel_hit     = pixel_hit;
endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed-vector bench for game_sprite_motion (default divider build, or vsync build when the macro is set).
module tb_game_sprite_motion;
    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef GAME_SPRITE_VSYNC_TICK_EN
    logic vsync_tick = 1'b0;
`endif
    int vec  = 0;
    int miss = 0;

    game_sprite_motion_if #(.X_WIDTH(10), .Y_WIDTH(10)) bus ();

    game_sprite_motion #(
        .X_WIDTH(10), .Y_WIDTH(10), .D_WIDTH(3),
        .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480),
        .SPRITE_W(8), .SPRITE_H(8),
        .START_X(320), .START_Y(400), .START_DX(1), .START_DY(-1),
        .STROBE_DIV(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef GAME_SPRITE_VSYNC_TICK_EN
        ,
        .vsync_tick (vsync_tick)
`endif
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int t633;
        int tws;
        bus.write_xy      = 1'b0;
        bus.write_dxy     = 1'b0;
        bus.enable_update = 1'b0;
        bus.pixel_x       = '0;
        bus.pixel_y       = '0;
        t633 = -1;
        tws  = -1;

        // 1. reset values and load
        cycles(3);
        check("rst_x", bus.sprite_x, 320);
        check("rst_y", bus.sprite_y, 400);
        check("rst_ws", bus.within_screen, 1);
        check("rst_hit", bus.pixel_hit, 0);
        reset = 1'b0;
        cycle();
        bus.write_xy = 1'b1;  cycle();  bus.write_xy = 1'b0;
        bus.write_dxy = 1'b1; cycle();  bus.write_dxy = 1'b0;
        check("load_x", bus.sprite_x, 320);
        check("load_y", bus.sprite_y, 400);
        check("load_ws", bus.within_screen, 1);

`ifdef GAME_SPRITE_VSYNC_TICK_EN
        // 6. vsync-driven steps
        bus.enable_update = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vsync_tick = 1'b1; cycle();
            vsync_tick = 1'b0; cycle();
        end
        check("vs_en_x", bus.sprite_x, 325);
        check("vs_en_y", bus.sprite_y, 395);
        cycles(4);
        check("vs_idle_x", bus.sprite_x, 325);
        bus.enable_update = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vsync_tick = 1'b1; cycle();
            vsync_tick = 1'b0; cycle();
        end
        check("vs_dis_x", bus.sprite_x, 325);
        bus.write_xy = 1'b1; cycle(); bus.write_xy = 1'b0;
        cycle();
`else
        // 2. three steps in twelve enabled cycles
        bus.enable_update = 1'b1;
        cycles(3);
        check("step_pre_x", bus.sprite_x, 320);
        cycle();
        check("step1_x", bus.sprite_x, 321);
        check("step1_y", bus.sprite_y, 399);
        cycles(8);
        bus.enable_update = 1'b0;
        check("step3_x", bus.sprite_x, 323);
        check("step3_y", bus.sprite_y, 397);

        // 3. write_xy on a tick cycle, then counter restart
        bus.enable_update = 1'b1;
        cycles(3);
        bus.write_xy = 1'b1; cycle(); bus.write_xy = 1'b0;
        check("wxy_tick_x", bus.sprite_x, 320);
        check("wxy_tick_y", bus.sprite_y, 400);
        cycles(3);
        check("restart_pre_x", bus.sprite_x, 320);
        cycle();
        check("restart_x", bus.sprite_x, 321);
        check("restart_y", bus.sprite_y, 399);

        // 4. run to the right edge and freeze
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (bus.sprite_x == 633 && t633 < 0) t633 = i;
            if (!bus.within_screen) begin
                tws = i;
                break;
            end
        end
        check("edge_ws", bus.within_screen, 0);
        check("edge_lag", tws - t633, 1);
        check("edge_x", bus.sprite_x, 633);
        check("edge_y", bus.sprite_y, 87);
        cycles(20);
        check("freeze_x", bus.sprite_x, 633);
        check("freeze_y", bus.sprite_y, 87);
        bus.enable_update = 1'b0;
        bus.write_xy = 1'b1; cycle(); bus.write_xy = 1'b0;
        check("unfreeze_x", bus.sprite_x, 320);
        check("unfreeze_ws_lag", bus.within_screen, 0);
        cycle();
        check("unfreeze_ws", bus.within_screen, 1);
`endif

        // 5. pixel hit sweep
        bus.pixel_y = 10'd400;
        for (int px = 319; px <= 328; px++) begin
            bus.pixel_x = 10'(px);
            cycle();
            check($sformatf("hit_x%0d", px), bus.pixel_hit, (px >= 320 && px <= 327) ? 1 : 0);
        end
        bus.pixel_x = 10'd320;
        bus.pixel_y = 10'd407; cycle(); check("hit_y407", bus.pixel_hit, 1);
        bus.pixel_y = 10'd408; cycle(); check("hit_y408", bus.pixel_hit, 0);
        bus.pixel_y = 10'd399; cycle(); check("hit_y399", bus.pixel_hit, 0);

        // reset mid-motion
        bus.enable_update = 1'b1;
        cycles(6);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_x", bus.sprite_x, 320);
        check("mid_rst_y", bus.sprite_y, 400);
        check("mid_rst_ws", bus.within_screen, 1);
        check("mid_rst_hit", bus.pixel_hit, 0);
        @(negedge clk);
        reset = 1'b0;
        cycles(8);
        check("rst_dx0_x", bus.sprite_x, 320);

`ifndef GAME_SPRITE_VSYNC_TICK_EN
        // write_dxy on a tick cycle uses the old (zero) velocity
        cycles(3);
        bus.write_dxy = 1'b1; cycle(); bus.write_dxy = 1'b0;
        check("wdxy_tick_x", bus.sprite_x, 320);
        cycles(4);
        check("wdxy_next_x", bus.sprite_x, 321);
        check("wdxy_next_y", bus.sprite_y, 399);
`endif
        bus.enable_update = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
